// File: rtl/pe_operand_reader.sv
// pe_operand_reader: streams one bank of A entries against each B word, forwarding B to the next PE.
// Define PE_READER_PERF_EN to add stall_cnt_out (FETCH cycles spent waiting on an empty B FIFO).
module pe_operand_reader #(
  parameter int D_WIDTH      = 64,
  parameter int PE_NUM       = 4,
  parameter int PE_NUM_WIDTH = 2,
  parameter int B_NUM        = 4,
  parameter int B_NUM_WIDTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              bank_full_in,
  output logic [1:0]              bank_release_out,
  output logic                    ram_rd_en_out,
  output logic [PE_NUM_WIDTH:0]   ram_rd_addr_out,
  input  logic [D_WIDTH-1:0]      ram_rd_data_in,
  input  logic [D_WIDTH-1:0]      data_B_FIFO_in,
  input  logic                    valid_B_FIFO_in,
  output logic                    RD_EN_B_FIFO_out,
  output logic [D_WIDTH-1:0]      data_B_FIFO_out,
  output logic                    WR_EN_B_FIFO_out,
  output logic [D_WIDTH-1:0]      data_A_out,
  output logic [D_WIDTH-1:0]      data_B_out,
  output logic                    valid_AB_out,
  output logic                    last_out
`ifdef PE_READER_PERF_EN
  ,
  output logic [31:0]             stall_cnt_out
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, STREAM, RELEASE} state_t;
  localparam logic [PE_NUM_WIDTH-1:0] K_LAST = PE_NUM_WIDTH'(PE_NUM - 1);
  localparam logic [B_NUM_WIDTH-1:0]  J_LAST = B_NUM_WIDTH'(B_NUM - 1);
  state_t                  state, state_nxt;
  logic                    cur;
  logic [PE_NUM_WIDTH-1:0] k;
  logic [B_NUM_WIDTH-1:0]  j;
  logic [D_WIDTH-1:0]      b_reg;
  logic                    valid_q, last_q;
  logic                    k_end, j_end, stream, fwd;
  assign stream = state == STREAM;
  assign k_end  = k == K_LAST;
  assign j_end  = j == J_LAST;
  assign fwd    = stream && k == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bank_full_in[cur] ? FETCH : IDLE;
      FETCH:   state_nxt = valid_B_FIFO_in ? STREAM : FETCH;
      STREAM:  state_nxt = !k_end ? STREAM : j_end ? RELEASE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    ram_rd_en_out    = stream;
    ram_rd_addr_out  = stream ? {cur, k} : '0;
    RD_EN_B_FIFO_out = state == FETCH && valid_B_FIFO_in;
    WR_EN_B_FIFO_out = fwd;
    data_B_FIFO_out  = fwd ? data_B_FIFO_in : '0;
    bank_release_out = state == RELEASE ? (cur ? 2'b10 : 2'b01) : 2'b00;
    valid_AB_out     = valid_q;
    last_out         = last_q;
    data_A_out       = valid_q ? ram_rd_data_in : '0;
    data_B_out       = b_reg;
  end
  // A data returns one cycle after the read, so valid/last ride a one-stage pipe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur     <= 1'b0;
      k       <= '0;
      j       <= '0;
      b_reg   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= stream;
      last_q  <= stream && k_end && j_end;
      if (stream) k <= k_end ? '0 : k + 1'b1;
      if (stream && k_end && !j_end) j <= j + 1'b1;
      if (state == RELEASE) begin
        j   <= '0;
        cur <= ~cur;
      end
      if (fwd) b_reg <= data_B_FIFO_in;
    end
`ifdef PE_READER_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt_out <= '0;
    else if (state == FETCH && !valid_B_FIFO_in && stall_cnt_out != '1) stall_cnt_out <= stall_cnt_out + 1'b1;
`endif
endmodule

// File: tb/tb_pe_operand_reader.sv
// tb_pe_operand_reader: directed vectors for pe_operand_reader with PE_NUM=4, B_NUM=2.
module tb_pe_operand_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  bank_full = 2'b00;
  logic [1:0]  bank_release;
  logic        ram_rd_en;
  logic [2:0]  ram_rd_addr;
  logic [63:0] ram_q = '0;
  logic [63:0] fdata = '0;
  logic        valid_b;
  logic        rd_en_b;
  logic [63:0] fwd_data;
  logic        wr_en_fwd;
  logic [63:0] data_a, data_b;
  logic        valid_ab, last;
`ifdef PE_READER_PERF_EN
  logic [31:0] stall_cnt;
`endif
  logic [63:0] mem [8];
  logic [63:0] fbuf [16];
  int          wp = 0, rp = 0, cyc = 0;
  logic        hold = 1'b0;
  int          checks = 0, failures = 0;
  logic [63:0] pa[$], pb[$];
  logic        pl[$];
  int          pc[$], pops[$];
  logic [1:0]  rel[$];
  logic [63:0] wr[$];
  logic [2:0]  rda[$];

  pe_operand_reader #(.D_WIDTH(64), .PE_NUM(4), .PE_NUM_WIDTH(2), .B_NUM(2), .B_NUM_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bank_full_in(bank_full), .bank_release_out(bank_release),
    .ram_rd_en_out(ram_rd_en), .ram_rd_addr_out(ram_rd_addr), .ram_rd_data_in(ram_q),
    .data_B_FIFO_in(fdata), .valid_B_FIFO_in(valid_b), .RD_EN_B_FIFO_out(rd_en_b),
    .data_B_FIFO_out(fwd_data), .WR_EN_B_FIFO_out(wr_en_fwd), .data_A_out(data_a),
    .data_B_out(data_b), .valid_AB_out(valid_ab), .last_out(last)
`ifdef PE_READER_PERF_EN
    , .stall_cnt_out(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  assign valid_b = (wp != rp) && !hold;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd_en) ram_q <= mem[ram_rd_addr];
    if (rd_en_b && wp != rp) begin
      fdata <= fbuf[rp % 16];
      rp    <= rp + 1;
    end
  end

  always @(negedge clk)
    if (!rst) begin
      if (valid_ab) begin pa.push_back(data_a); pb.push_back(data_b); pl.push_back(last); pc.push_back(cyc); end
      if (bank_release != 2'b00) rel.push_back(bank_release);
      if (wr_en_fwd) wr.push_back(fwd_data);
      if (rd_en_b) pops.push_back(cyc);
      if (ram_rd_en) rda.push_back(ram_rd_addr);
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_b(input logic [63:0] v);
    fbuf[wp % 16] = v;
    wp = wp + 1;
  endtask

  task automatic clear_logs();
    pa.delete(); pb.delete(); pl.delete(); pc.delete(); pops.delete();
    rel.delete(); wr.delete(); rda.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bank_full = 2'b00;
    hold = 1'b0;
    @(negedge clk);
    wp = rp;
    clear_logs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    int t = 0;
    while (rel.size() < n && t < 300) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk($sformatf("release_seen_%0d", n), 64'(rel.size() >= n), 64'd1);
  endtask

  task automatic chk_pairs(input string tag, input int base, input int a_off, input int b0, input int b1);
    for (int i = 0; i < 8; i++)
      if (base + i < pa.size()) begin
        chk($sformatf("%s_a%0d", tag, i), pa[base+i], 64'(a_off + i % 4 + 1));
        chk($sformatf("%s_b%0d", tag, i), pb[base+i], 64'(i < 4 ? b0 : b1));
        chk($sformatf("%s_last%0d", tag, i), 64'(pl[base+i]), 64'(i == 7));
      end
  endtask

  initial begin
    int t;
    logic bad;
    for (int i = 0; i < 8; i++) mem[i] = 64'(i + 1);
    @(negedge clk);
    chk("rst_valid", 64'(valid_ab), 0);
    chk("rst_rd_en", 64'(ram_rd_en), 0);
    chk("rst_fifo_rd", 64'(rd_en_b), 0);
    chk("rst_release", 64'(bank_release), 0);
    chk("rst_data_b", data_b, 0);
    // Single bank, two B words; bank_full drops mid-bank
    do_reset();
    push_b(10); push_b(20);
    bank_full = 2'b01;
    t = 0;
    while (pa.size() == 0 && t < 50) begin @(negedge clk); t++; end
    bank_full = 2'b00;
    wait_rel(1);
    chk("t26_npairs", 64'(pa.size()), 8);
    chk_pairs("t26", 0, 0, 10, 20);
    if (pc.size() == 8) chk("t26_bubble", 64'(pc[4] - pc[3]), 2);
    if (pops.size() > 0 && pc.size() > 0) chk("t26_latency", 64'(pc[0] - pops[0]), 2);
    chk("t26_nrel", 64'(rel.size()), 1);
    if (rel.size() > 0) chk("t26_rel", 64'(rel[0]), 64'd1);
    chk("t26_nwr", 64'(wr.size()), 2);
    if (wr.size() == 2) begin chk("t26_wr0", wr[0], 10); chk("t26_wr1", wr[1], 20); end
    // Two banks back to back
    do_reset();
    push_b(30); push_b(40); push_b(50); push_b(60);
    bank_full = 2'b11;
    wait_rel(2);
    chk("t27_npairs", 64'(pa.size()), 16);
    chk_pairs("t27b0", 0, 0, 30, 40);
    chk_pairs("t27b1", 8, 4, 50, 60);
    if (rda.size() == 16) chk("t27_addr8", 64'(rda[8]), 64'd4);
    chk("t27_nrel", 64'(rel.size()), 2);
    if (rel.size() == 2) begin chk("t27_rel0", 64'(rel[0]), 1); chk("t27_rel1", 64'(rel[1]), 2); end
    // Five FETCH cycles with B FIFO held empty
    rst = 1'b1;
    bank_full = 2'b01;
    hold = 1'b1;
    @(negedge clk);
    wp = rp;
    clear_logs();
    push_b(70); push_b(80);
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin @(negedge clk); bad |= rd_en_b | valid_ab; end
    chk("t28_stalled", 64'(bad), 0);
    hold = 1'b0;
    wait_rel(1);
    chk("t28_npairs", 64'(pa.size()), 8);
    chk_pairs("t28", 0, 0, 70, 80);
`ifdef PE_READER_PERF_EN
    chk("t28_stall_cnt", 64'(stall_cnt), 5);
`endif
    // Reset while streaming entry k=2
    do_reset();
    push_b(90); push_b(100);
    bank_full = 2'b01;
    t = 0;
    while (!(ram_rd_en && ram_rd_addr == 3'd2) && t < 50) begin @(negedge clk); t++; end
    chk("t29_reached_k2", 64'(ram_rd_en && ram_rd_addr == 3'd2), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t29_valid", 64'(valid_ab), 0);
    chk("t29_rd_en", 64'(ram_rd_en), 0);
    chk("t29_data_b", data_b, 0);
    chk("t29_last", 64'(last), 0);
    chk("t29_norel", 64'(rel.size()), 0);
    wp = rp;
    clear_logs();
    push_b(90); push_b(100);
    @(negedge clk);
    rst = 1'b0;
    wait_rel(1);
    chk("t29_npairs", 64'(pa.size()), 8);
    chk_pairs("t29", 0, 0, 90, 100);
    if (rda.size() > 0) chk("t29_addr0", 64'(rda[0]), 0);
    chk("t29_nrel", 64'(rel.size()), 1);
    if (rel.size() > 0) chk("t29_rel", 64'(rel[0]), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
